// File: rtl/spi_word_tx.sv
// SPI mode-0 word transmitter: one WIDTH-bit word per cs_n frame, MSB first.
// SCLK half-period is DIV clk cycles; every pin is driven straight from a flop.
module spi_word_tx #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n,
    output logic             done
);

    localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HALF_W = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [WIDTH-1:0]    sreg_q, sreg_d;
    logic                sclk_d, mosi_d, cs_n_d, done_d, tx_ready_d;

    logic                accept_c;
    logic                half_end_c;
    logic                last_half_c;
    logic                last_fall_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic [WIDTH-1:0]    shifted_c;

    assign accept_c    = tx_valid & tx_ready;
    assign half_end_c  = (cnt_q == CNT_W'(DIV - 1));
    assign last_half_c = (half_q == HALF_W'(2 * WIDTH - 1));
    assign last_fall_c = (half_q == HALF_W'(2 * WIDTH - 2));
    assign cnt_inc_c   = half_end_c ? '0 : cnt_q + CNT_W'(1);
    assign shifted_c   = sreg_q << 1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept_c)                   state_d = SETUP;
            SETUP: if (half_end_c)                 state_d = SHIFT;
            SHIFT: if (half_end_c && last_half_c)  state_d = HOLD;
            HOLD:  if (half_end_c)                 state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    // Next values of the output and datapath flops
    always_comb begin
        cnt_d      = cnt_q;
        half_d     = half_q;
        sreg_d     = sreg_q;
        sclk_d     = sclk;
        mosi_d     = mosi;
        cs_n_d     = cs_n;
        done_d     = 1'b0;
        tx_ready_d = (state_d == IDLE);
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                half_d = '0;
                sclk_d = 1'b0;
                if (accept_c) begin
                    sreg_d = tx_data;
                    mosi_d = tx_data[WIDTH-1];
                    cs_n_d = 1'b0;
                end else begin
                    mosi_d = 1'b0;
                    cs_n_d = 1'b1;
                end
            end
            SETUP: begin
                cnt_d = cnt_inc_c;
                if (half_end_c) begin
                    sclk_d = 1'b1;
                    half_d = '0;
                end
            end
            SHIFT: begin
                cnt_d = cnt_inc_c;
                if (half_end_c && !last_half_c) begin
                    half_d = half_q + HALF_W'(1);
                    sclk_d = ~sclk;
                    // Falling edge presents the next bit; the final one keeps bit 0
                    if (sclk && !last_fall_c) begin
                        sreg_d = shifted_c;
                        mosi_d = shifted_c[WIDTH-1];
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_inc_c;
                if (half_end_c) begin
                    cs_n_d = 1'b1;
                    mosi_d = 1'b0;
                    done_d = 1'b1;
                    half_d = '0;
                    sreg_d = '0;
                end
            end
            default: begin
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                sclk_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            half_q   <= '0;
            sreg_q   <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            done     <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            sreg_q   <= sreg_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
            cs_n     <= cs_n_d;
            done     <= done_d;
            tx_ready <= tx_ready_d;
        end
    end

endmodule

// File: tb/tb_spi_word_tx.sv
// Scoreboard bench for spi_word_tx: a DIV=4 and a DIV=1 instance, each watched
// by a slave-side monitor that rebuilds words on rising sclk and checks framing.
module tb_spi_word_tx;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [W-1:0] tx_data_a, tx_data_b;
    logic         tx_valid_a, tx_valid_b;
    logic         tx_ready_a, sclk_a, mosi_a, cs_n_a, done_a;
    logic         tx_ready_b, sclk_b, mosi_b, cs_n_b, done_b;

    spi_word_tx #(.DIV(4), .WIDTH(W)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .done(done_a)
    );

    spi_word_tx #(.DIV(1), .WIDTH(W)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .done(done_b)
    );

    logic [1:0] sclk_v, mosi_v, cs_v, done_v, rdy_v;
    assign sclk_v = {sclk_b, sclk_a};
    assign mosi_v = {mosi_b, mosi_a};
    assign cs_v   = {cs_n_b, cs_n_a};
    assign done_v = {done_b, done_a};
    assign rdy_v  = {tx_ready_b, tx_ready_a};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // Monitor state, one slot per instance
    int           div_v[2] = '{4, 1};
    int           cyc = 0;
    int           low_cnt[2], bits[2], last_rise[2], spacing_bad[2], done_cnt[2];
    logic [W-1:0] shreg[2];
    logic         prev_sclk[2], prev_cs[2], prev_done[2];
    logic [W-1:0] exp_w;

    initial begin
        for (int d = 0; d < 2; d++) begin
            low_cnt[d] = 0; bits[d] = 0; last_rise[d] = 0; spacing_bad[d] = 0;
            done_cnt[d] = 0; shreg[d] = '0; prev_sclk[d] = 1'b0; prev_cs[d] = 1'b1;
            prev_done[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                // Aborted frame is discarded; no done may appear
                if (done_v[d]) chk("done_in_reset", 32'(done_v[d]), 32'd0);
                low_cnt[d] = 0; bits[d] = 0; spacing_bad[d] = 0; shreg[d] = '0;
                prev_cs[d] = 1'b1; prev_sclk[d] = 1'b0; prev_done[d] = 1'b0;
            end else begin
                if (!cs_v[d]) begin
                    low_cnt[d]++;
                    if (sclk_v[d] && !prev_sclk[d]) begin
                        if (bits[d] > 0 && (cyc - last_rise[d]) != 2 * div_v[d]) spacing_bad[d]++;
                        last_rise[d] = cyc;
                        shreg[d] = {shreg[d][W-2:0], mosi_v[d]};
                        bits[d]++;
                    end
                end
                if (cs_v[d] && !prev_cs[d]) begin
                    chk("done_at_frame_end", 32'(done_v[d]), 32'd1);
                    chk("mosi_idle", 32'(mosi_v[d]), 32'd0);
                    chk("sclk_idle", 32'(sclk_v[d]), 32'd0);
                    chk("cs_low_cycles", 32'(low_cnt[d]), 32'((2 * W + 2) * div_v[d]));
                    chk("sclk_rises", 32'(bits[d]), 32'(W));
                    chk("sclk_period", 32'(spacing_bad[d]), 32'd0);
                    if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        chk("unexpected_frame", 32'(shreg[d]), 32'hDEAD_BEEF);
                    end else begin
                        exp_w = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk(d == 0 ? "word_div4" : "word_div1", 32'(shreg[d]), 32'(exp_w));
                    end
                    low_cnt[d] = 0; bits[d] = 0; spacing_bad[d] = 0; shreg[d] = '0;
                end else if (done_v[d]) begin
                    chk("stray_done", 32'(done_v[d]), 32'd0);
                end
                if (done_v[d] && prev_done[d]) chk("done_width", 32'd2, 32'd1);
                if (done_v[d]) done_cnt[d]++;
                prev_cs[d]   = cs_v[d];
                prev_sclk[d] = sclk_v[d];
                prev_done[d] = done_v[d];
            end
        end
    end

    task automatic drive(input int d, input logic v, input logic [W-1:0] data);
        if (d == 0) begin tx_valid_a = v; tx_data_a = data; end
        else        begin tx_valid_b = v; tx_data_b = data; end
    endtask

    // Wait for ready, present one word for one cycle, then scribble on tx_data
    task automatic send(input int d, input logic [W-1:0] v, input bit push);
        int t = 0;
        while (!rdy_v[d] && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) chk("ready_timeout", 32'(t), 32'd0);
        drive(d, 1'b1, v);
        if (push) begin
            if (d == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
        end
        @(negedge clk);
        drive(d, 1'b0, ~v);
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        do begin @(negedge clk); t++; end while (!done_v[d] && t < 1000);
        if (t >= 1000) chk("done_timeout", 32'(t), 32'd0);
    endtask

    int snap, rises;
    logic ps;

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_mosi", 32'(mosi_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready_a), 32'd0);
        #2 rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(tx_ready_a), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(tx_ready_a), 32'd1);

        // Single word
        send(0, 16'hA55A, 1'b1);
        chk("busy_ready", 32'(tx_ready_a), 32'd0);
        wait_done(0);
        chk("ready_on_done", 32'(tx_ready_a), 32'd1);

        // Back-to-back with tx_valid held high
        drive(0, 1'b1, 16'h0077);
        exp_q0.push_back(16'h0077);
        exp_q0.push_back(16'h0066);
        @(negedge clk);
        drive(0, 1'b1, 16'h0066);
        wait_done(0);
        chk("gap_cs_high", 32'(cs_n_a), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 16'h5555);
        chk("gap_one_cycle", 32'(cs_n_a), 32'd0);
        wait_done(0);

        // Busy rejection
        send(0, 16'h1234, 1'b1);
        repeat (40) @(negedge clk);
        drive(0, 1'b1, 16'hFFFF);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("no_extra_frame", 32'(cs_n_a), 32'd1);

        // DIV=1
        send(1, 16'h8001, 1'b1);
        wait_done(1);

        // Reset after 5 rising sclk edges
        snap = done_cnt[0];
        send(0, 16'hBEEF, 1'b0);
        rises = 0; ps = sclk_a;
        for (int t = 0; t < 1000 && rises < 5; t++) begin
            @(negedge clk);
            if (sclk_a && !ps) rises++;
            ps = sclk_a;
        end
        chk("rises_before_reset", 32'(rises), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(cs_n_a), 32'd1);
        chk("abort_sclk", 32'(sclk_a), 32'd0);
        chk("abort_mosi", 32'(mosi_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt[0]), 32'(snap));
        send(0, 16'h00FF, 1'b1);
        wait_done(0);

        repeat (5) @(negedge clk);
        chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
        chk("queue1_drained", 32'(exp_q1.size()), 32'd0);
        chk("done_count_div4", 32'(done_cnt[0]), 32'd5);
        chk("done_count_div1", 32'(done_cnt[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
